// File: rtl/logic_gate_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with selectable gate and an operand-equality counter.
// Latency STAGES cycles; one global advance enable, so a stalled output freezes every stage and drops in_ready.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_match,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             w_en;
    logic [WIDTH-1:0] w_y;
    logic             w_match;
    logic             w_out_xfer;

    logic             r_vld   [STAGES];
    logic [WIDTH-1:0] r_y     [STAGES];
    logic             r_match [STAGES];
    logic [CNT_W-1:0] r_cnt;

    // A bubble at the output never blocks, so the pipe only stalls on a real held beat.
    assign w_en       = !out_valid || out_ready;
    assign in_ready   = w_en;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_y = '0;
        case (in_op)
            OP_AND:  w_y = in_a & in_b;
            OP_OR:   w_y = in_a | in_b;
            OP_XOR:  w_y = in_a ^ in_b;
            OP_XNOR: w_y = ~(in_a ^ in_b);
            OP_NAND: w_y = ~(in_a & in_b);
            OP_NOR:  w_y = ~(in_a | in_b);
            OP_PASS: w_y = in_a;
            default: w_y = ~in_a;
        endcase
    end

    assign w_match = &(~(in_a ^ in_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s]   <= 1'b0;
                r_y[s]     <= '0;
                r_match[s] <= 1'b0;
            end
        end else if (w_en) begin
            r_vld[0]   <= in_valid;
            r_y[0]     <= w_y;
            r_match[0] <= w_match;
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s]   <= r_vld[s-1];
                r_y[s]     <= r_y[s-1];
                r_match[s] <= r_match[s-1];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_y     = r_y[STAGES-1];
    assign out_match = r_match[STAGES-1];

    // Clear takes priority over a same-cycle matching delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear_cnt) begin
            r_cnt <= '0;
        end else if (w_out_xfer && out_match && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign match_count = r_cnt;

endmodule
